// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 16-bit ALU. It accepts one instruction at a time,
// reads operands from an internal 8-entry register file, drives the ALU, and writes the result back.
module alu_issue_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             done,
    output logic             illegal,
    output logic             zero_flag,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    // state | meaning
    // IDLE  | ready for a new instruction
    // READ  | read operands, load the ALU inputs
    // EXEC  | ALU inputs held, capture the result
    // WB    | write back the result and the zero flag
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t state, state_nxt;

    logic [15:0]      ir;
    logic [WIDTH-1:0] regs [8];
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic [3:0]       opcode;
    logic [2:0]       rd, rs1, rs2;
    logic [5:0]       imm6;
    logic             op_legal;
    logic [2:0]       op_ctrl;
    logic [WIDTH-1:0] op_b;

    assign opcode = ir[15:12];
    assign rd     = ir[11:9];
    assign rs1    = ir[8:6];
    assign rs2    = ir[5:3];
    assign imm6   = ir[5:0];

    always_comb begin
        op_legal = 1'b1;
        op_ctrl  = 3'b000;
        op_b     = regs[rs2];
        case (opcode)
            4'h0: op_ctrl = 3'b000;
            4'h1: op_ctrl = 3'b001;
            4'h2: op_ctrl = 3'b011;
            4'h3: begin
                op_ctrl = 3'b000;
                op_b    = {{(WIDTH-6){imm6[5]}}, imm6};
            end
            4'h4: begin
                op_ctrl = 3'b011;
                op_b    = {{(WIDTH-4){1'b0}}, imm6[3:0]};
            end
            default: begin
                op_legal = 1'b0;
                op_b     = '0;
            end
        endcase
    end

    assign instr_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir          <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= 3'b000;
            result_q    <= '0;
            zero_q      <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            zero_flag   <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: if (instr_valid) ir <= instr;
                READ: begin
                    // Undefined opcodes still run the full pipeline, with a quiet ALU.
                    alu_a       <= op_legal ? regs[rs1] : '0;
                    alu_b       <= op_b;
                    alu_control <= op_ctrl;
                end
                EXEC: begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                end
                WB: begin
                    done    <= 1'b1;
                    illegal <= ~op_legal;
                    if (op_legal) begin
                        zero_flag <= zero_q;
                        if (rd != 3'd0) regs[rd] <= result_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU (add, sub, shift-left) on the
// ALU side of the controller.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_control;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        done, illegal, zero_flag;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_pass = 0;
    int n_checks = 0;

    alu_issue_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .done(done), .illegal(illegal),
        .zero_flag(zero_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_control)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b011: alu_result = (alu_b >= 16'd16) ? 16'h0000 : (alu_a << alu_b[3:0]);
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 16'h0000);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic rd_reg(input logic [2:0] addr, input logic [15:0] exp, input string tag);
        dbg_addr = addr;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Drive one instruction and follow it through the fixed 4-cycle pipeline.
    task automatic issue(input logic [15:0] ins, input logic [15:0] ea, input logic [15:0] eb,
                         input logic [2:0] ec, input logic eill, input string tag);
        int waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_ready_wait"}, {15'b0, instr_ready}, 16'h1);
        instr_valid = 1'b1;
        instr = ins;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk({tag, "_busy"}, {15'b0, instr_ready}, 16'h0);
        @(posedge clk); #1;
        chk({tag, "_alu_a"}, alu_a, ea);
        chk({tag, "_alu_b"}, alu_b, eb);
        chk({tag, "_alu_ctrl"}, {13'b0, alu_control}, {13'b0, ec});
        @(posedge clk); #1;
        chk({tag, "_done_early"}, {15'b0, done}, 16'h0);
        @(posedge clk); #1;
        chk({tag, "_done"}, {15'b0, done}, 16'h1);
        chk({tag, "_illegal"}, {15'b0, illegal}, {15'b0, eill});
        chk({tag, "_ready_back"}, {15'b0, instr_ready}, 16'h1);
        @(posedge clk); #1;
        chk({tag, "_done_clear"}, {15'b0, done}, 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0000;
        dbg_addr = 3'd0;
        #1;
        chk("rst_ready", {15'b0, instr_ready}, 16'h1);
        chk("rst_alu_a", alu_a, 16'h0000);
        chk("rst_alu_b", alu_b, 16'h0000);
        chk("rst_ctrl", {13'b0, alu_control}, 16'h0000);
        chk("rst_done", {15'b0, done}, 16'h0);
        chk("rst_zero", {15'b0, zero_flag}, 16'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: ADDI r1,r0,5
        issue(16'h3205, 16'h0000, 16'h0005, 3'b000, 1'b0, "addi_r1");
        rd_reg(3'd1, 16'h0005, "r1_after_addi");
        chk("zf_addi", {15'b0, zero_flag}, 16'h0);

        // 2: ADDI r2,r0,-3 ; SUB r3,r1,r1
        issue(16'h343D, 16'h0000, 16'hFFFD, 3'b000, 1'b0, "addi_neg");
        rd_reg(3'd2, 16'hFFFD, "r2_neg");
        issue(16'h1648, 16'h0005, 16'h0005, 3'b001, 1'b0, "sub_r3");
        rd_reg(3'd3, 16'h0000, "r3_sub");
        chk("zf_sub", {15'b0, zero_flag}, 16'h1);

        // 3: SLLI r4,r1,4 ; SLL r5,r1,r2 with an oversized shift
        issue(16'h4844, 16'h0005, 16'h0004, 3'b011, 1'b0, "slli_r4");
        rd_reg(3'd4, 16'h0050, "r4_slli");
        chk("zf_slli", {15'b0, zero_flag}, 16'h0);
        issue(16'h2A50, 16'h0005, 16'hFFFD, 3'b011, 1'b0, "sll_big");
        rd_reg(3'd5, 16'h0000, "r5_sll_big");
        chk("zf_sll_big", {15'b0, zero_flag}, 16'h1);

        // 4: illegal opcode, then a write to r0
        issue(16'hF000, 16'h0000, 16'h0000, 3'b000, 1'b1, "illegal");
        rd_reg(3'd1, 16'h0005, "r1_after_ill");
        rd_reg(3'd4, 16'h0050, "r4_after_ill");
        chk("zf_after_ill", {15'b0, zero_flag}, 16'h1);
        issue(16'h3005, 16'h0000, 16'h0005, 3'b000, 1'b0, "addi_r0");
        rd_reg(3'd0, 16'h0000, "r0_const");
        chk("zf_r0_write", {15'b0, zero_flag}, 16'h0);

        // 5: valid held high across two instructions (ADDI r6,r0,7 ; ADDI r7,r1,1)
        @(negedge clk);
        instr_valid = 1'b1;
        instr = 16'h3C07;
        @(posedge clk); #1;
        instr = 16'h3E41;
        chk("b2b_busy0", {15'b0, instr_ready}, 16'h0);
        @(posedge clk); #1;
        chk("b2b_busy1", {15'b0, instr_ready}, 16'h0);
        @(posedge clk); #1;
        chk("b2b_busy2", {15'b0, instr_ready}, 16'h0);
        chk("b2b_nodone", {15'b0, done}, 16'h0);
        @(posedge clk); #1;
        chk("b2b_done1", {15'b0, done}, 16'h1);
        chk("b2b_ready1", {15'b0, instr_ready}, 16'h1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("b2b_accept2", {15'b0, instr_ready}, 16'h0);
        chk("b2b_done_lo", {15'b0, done}, 16'h0);
        @(posedge clk); #1;
        chk("b2b_alu_a2", alu_a, 16'h0005);
        @(posedge clk); #1;
        chk("b2b_busy2b", {15'b0, instr_ready}, 16'h0);
        @(posedge clk); #1;
        chk("b2b_done2", {15'b0, done}, 16'h1);
        rd_reg(3'd6, 16'h0007, "r6_b2b");
        rd_reg(3'd7, 16'h0006, "r7_b2b");

        // 6: reset during EXEC aborts the instruction
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = 16'h3205;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_pre_b", alu_b, 16'h0005);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_ready", {15'b0, instr_ready}, 16'h1);
        chk("abort_alu_a", alu_a, 16'h0000);
        chk("abort_alu_b", alu_b, 16'h0000);
        rd_reg(3'd1, 16'h0000, "abort_r1");
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_nodone", {15'b0, done}, 16'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        rd_reg(3'd1, 16'h0000, "abort_r1_after");
        issue(16'h3205, 16'h0000, 16'h0005, 3'b000, 1'b0, "post_abort");
        rd_reg(3'd1, 16'h0005, "r1_post_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
